otp_codegen: RTL
================

# otp_codegen

Parametrised one-time-password code generator: takes a finished HMAC digest, applies RFC 4226 dynamic truncation, reduces modulo 10^DIGITS, and optionally converts the result to BCD for the display path. It sits between the HMAC controller's digest output and the seven-segment/LED drivers, and is the next-generation replacement for the fixed 6-digit, SHA-1-only sampler. It adds selectable digest width, digit count, a busy/ready handshake, and multi-cycle arithmetic.

## Interface
- DIGEST_W, 160: digest width in bits; legal values are 160 (SHA-1) and 256 (SHA-256).
- DIGITS, 6: output digit count; legal range is 1..9.
- BIN_W, localparam: clog2(10^DIGITS); width of the binary code.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous and active-high.
- init  in  1  start pulse; sampled only when the block is not busy.
- digest  in  DIGEST_W  HMAC result; bit [DIGEST_W-1] is the MSB of byte 0; sampled on the accepting edge.
- busy  out  1  high while a computation is in flight.
- ready  out  1  level signal: result is valid; held until the next accepted init or reset.
- code  out  BIN_W  binary OTP value, range 0..10^DIGITS-1.
- bcd  out  4*DIGITS  packed BCD; least significant digit in bits [3:0].

## Operation
- FSM states: IDLE, TRUNC, MOD, BCD, DONE.
- Reset (synchronous) forces IDLE and clears busy, ready, code, bcd and all internal registers. Reset mid-operation aborts the computation with no output change beyond the clear.
- init is accepted in IDLE or DONE only. On acceptance:
  - digest is latched;
  - ready drops on the next cycle;
  - busy rises on the next cycle.
- init while busy is ignored.
- TRUNC (1 cycle):
  - offset = low nibble of the last byte (digest[3:0]);
  - P = bytes offset..offset+3, big-endian, with bit 31 cleared (31-bit value);
  - the maximum byte index is 18, in range for both widths.
- MOD (31 cycles): restoring reduction.
  - Each cycle shifts the next bit of P (MSB first) into a BIN_W+1-bit remainder.
  - The remainder is conditionally reduced by M = 10^DIGITS.
  - Final remainder = P mod M, latched into code.
- BCD (BIN_W cycles): shift-add-3 conversion of code into bcd.
- DONE: busy=0, ready=1; code and bcd stay stable.
- No arithmetic overflow: the remainder width of BIN_W+1 bits always covers 2M-1.

## Timing
- init accepted at edge k. Then:
  - TRUNC occupies cycle k+1;
  - MOD occupies k+2..k+32;
  - BCD occupies k+33..k+32+BIN_W;
  - ready goes high and busy goes low at edge k+33+BIN_W.
- For DIGITS=6 (BIN_W=20), ready rises 53 edges after init.
- Without OTP_BCD_EN, ready rises at edge k+33.
- busy is high from edge k+1 until ready rises, inclusive of all intermediate states.
- init in DONE on the same edge that ready is observed is accepted; the restart is identical to one from IDLE.
- code and bcd change only on the edge entering DONE, or on reset. They are never glitched mid-computation.

## Configuration
- OTP_BCD_EN defined:
  - the BCD state and converter are compiled in;
  - bcd carries the decimal digits of code.
- OTP_BCD_EN undefined:
  - the BCD state is skipped (MOD goes to DONE);
  - bcd is tied to 0;
  - latency is 33 edges regardless of DIGITS.

## Structure
- Shared package otp_pkg contains:
  - the state enumeration;
  - constant function pow10(n) returning a 32-bit 10^n;
  - bin_width(n) returning clog2(10^n);
  - localparam TRUNC_W = 31.
- One sub-module: otp_bcd_conv.
  - Sequential shift-add-3 converter, parametrised by BIN_W and DIGITS.
  - start/done handshake; done pulses for one cycle.
  - Instantiated only under OTP_BCD_EN.

## Test plan
- RFC 4226 vector, DIGEST_W=160, DIGITS=6: digest 1f8698690e02ca16618550ef7f19da8e945b555a -> offset 0xa, P=0x50ef7f19, code=872921, bcd=0x872921, ready at edge +53.
- Same digest, DIGITS=8 -> code=57872921, bcd=0x57872921.
- DIGEST_W=256, DIGITS=9: bytes 0..3=0xFFFFFFFF, last byte 0x00 -> P=0x7FFFFFFF, code=147483647.
- init pulsed at cycle 10 of a busy computation -> ignored; the original result appears on schedule; the next init in DONE restarts, with ready dropping one cycle later.
- rst asserted during MOD -> next edge: busy=0, ready=0, code=0, bcd=0, state IDLE; a subsequent init completes normally.
- Build without OTP_BCD_EN, RFC vector -> code=872921, bcd=0, ready at edge +33.

Source files
------------

// File: rtl/otp_pkg.sv
// Shared definitions for the OTP code generator: FSM state encoding,
// truncation width and constant helpers for decimal modulus sizing.
package otp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRUNC = 3'd1,
        MOD   = 3'd2,
        BCD   = 3'd3,
        DONE  = 3'd4
    } otp_state_t;

    // Width of the dynamically truncated value (bit 31 always cleared).
    localparam int TRUNC_W = 31;

    // 10^n as a 32-bit constant; n is at most 9 so the result always fits.
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 32'd10;
        end
        return v;
    endfunction

    // Smallest w with 2^w >= 10^n, i.e. clog2(10^n).
    function automatic int bin_width(input int n);
        logic [63:0] m;
        int          w;
        m = {32'd0, pow10(n)};
        w = 0;
        for (int i = 0; i < 40; i++) begin
            if ((64'd1 << i) < m) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/otp_bcd_conv.sv
// Sequential shift-add-3 (double dabble) binary to packed BCD converter.
// A start pulse loads the value and performs the first iteration on the same
// edge; the remaining BIN_W-1 iterations follow on consecutive edges. done
// pulses for one cycle once bcd holds the final digits.
module otp_bcd_conv #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      value,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    logic [BIN_W-1:0] bin_r;
    logic [BCD_W-1:0] bcd_r;
    logic [BCD_W-1:0] adj_s;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;

    // Digit adjustment of the current accumulator.
    always_comb begin
        adj_s = add3_digits(bcd_r);
    end

    // Shift engine: load on start, then one adjust-and-shift per edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r  <= '0;
            bcd_r  <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (start) begin
            bcd_r  <= {{(BCD_W-1){1'b0}}, value[BIN_W-1]};
            bin_r  <= value << 1;
            cnt_r  <= CNT_W'(BIN_W - 1);
            done_r <= 1'b0;
        end else if (cnt_r != '0) begin
            bcd_r  <= (adj_s << 1) | {{(BCD_W-1){1'b0}}, bin_r[BIN_W-1]};
            bin_r  <= bin_r << 1;
            cnt_r  <= cnt_r - CNT_W'(1);
            done_r <= (cnt_r == CNT_W'(1));
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/otp_codegen.sv
// One-time-password code generator: dynamic truncation of an HMAC digest,
// restoring reduction modulo 10^DIGITS and optional BCD conversion.
// Build option OTP_BCD_EN: when defined, the BCD state and converter are
// present and bcd carries the decimal digits of code; otherwise bcd is 0 and
// the result is ready 33 edges after init.
module otp_codegen
    import otp_pkg::*;
#(
    parameter int  DIGEST_W = 160,
    parameter int  DIGITS   = 6,
    localparam int BIN_W    = bin_width(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic [DIGEST_W-1:0]   digest,
    output logic                  busy,
    output logic                  ready,
    output logic [BIN_W-1:0]      code,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int             IDX_W = $clog2(DIGEST_W);
    localparam logic [BIN_W:0] MOD_M = (BIN_W + 1)'(pow10(DIGITS));

    otp_state_t          state_r;
    logic [DIGEST_W-1:0] digest_r;
    logic [TRUNC_W-1:0]  p_r;
    logic [BIN_W:0]      rem_r;
    logic [4:0]          cnt_r;
    logic                busy_r;
    logic                ready_r;
    logic [BIN_W-1:0]    code_r;

    logic [3:0]          off_s;
    logic [IDX_W-1:0]    base_s;
    logic [TRUNC_W-1:0]  p_s;
    logic [BIN_W:0]      shift_s;
    logic [BIN_W:0]      rem_next_s;

    // Truncation window and one restoring-reduction step.
    always_comb begin
        off_s   = digest_r[3:0];
        // Byte 'off' starts at bit DIGEST_W-1-8*off; skipping its MSB clears bit 31.
        base_s  = IDX_W'(DIGEST_W - 2) - IDX_W'({off_s, 3'b000});
        p_s     = digest_r[base_s -: TRUNC_W];
        // Remainder is always below M, so doubling plus one bit stays below 2M.
        shift_s = (rem_r << 1) | {{BIN_W{1'b0}}, p_r[TRUNC_W-1]};
        if (shift_s >= MOD_M) begin
            rem_next_s = shift_s - MOD_M;
        end else begin
            rem_next_s = shift_s;
        end
    end

`ifdef OTP_BCD_EN
    logic                conv_start_s;
    logic                conv_done_s;
    logic [4*DIGITS-1:0] conv_bcd_s;
    logic [4*DIGITS-1:0] bcd_r;

    // Converter launches on the final MOD edge, reading the finished remainder.
    always_comb begin
        conv_start_s = (state_r == MOD) && (cnt_r == 5'd31);
    end

    otp_bcd_conv #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bcd_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_s),
        .value (rem_r[BIN_W-1:0]),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );
`endif

    // Control FSM: handshake, truncation, reduction and result latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            digest_r <= '0;
            p_r      <= '0;
            rem_r    <= '0;
            cnt_r    <= 5'd0;
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
            code_r   <= '0;
`ifdef OTP_BCD_EN
            bcd_r    <= '0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (init) begin
                        digest_r <= digest;
                        busy_r   <= 1'b1;
                        ready_r  <= 1'b0;
                        state_r  <= TRUNC;
                    end
                end
                TRUNC: begin
                    p_r     <= p_s;
                    rem_r   <= '0;
                    cnt_r   <= 5'd0;
                    state_r <= MOD;
                end
                MOD: begin
                    // Counts 0..30 consume the 31 bits of P; count 31 hands off the result.
                    if (cnt_r == 5'd31) begin
`ifdef OTP_BCD_EN
                        state_r <= BCD;
`else
                        code_r  <= rem_r[BIN_W-1:0];
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= DONE;
`endif
                    end else begin
                        rem_r <= rem_next_s;
                        p_r   <= p_r << 1;
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
`ifdef OTP_BCD_EN
                BCD: begin
                    if (conv_done_s) begin
                        code_r  <= rem_r[BIN_W-1:0];
                        bcd_r   <= conv_bcd_s;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= DONE;
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign ready = ready_r;
    assign code  = code_r;
`ifdef OTP_BCD_EN
    assign bcd   = bcd_r;
`else
    assign bcd   = {(4*DIGITS){1'b0}};
`endif

endmodule
